// File: rtl/subpel_interp_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : subpel_interp_stream_if
// Description : Pixel-in / sample-out valid-ready bundle for the streaming
//               sub-pel interpolator, plus frame status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface subpel_interp_stream_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pix;
    logic             in_sof;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pix;
    logic             frame_done;
    logic             frame_err;

    // Interpolator side
    modport slave (
        input  in_valid, in_pix, in_sof, mode, out_ready,
        output in_ready, out_valid, out_pix, frame_done, frame_err
    );

    // Pixel source / sample sink side
    modport master (
        output in_valid, in_pix, in_sof, mode, out_ready,
        input  in_ready, out_valid, out_pix, frame_done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/subpel_interp_stream.sv
`default_nettype none
// ============================================================================
// Module      : subpel_interp_stream
// Description : Streaming 6-tap sub-pel interpolator. Buffers a horizontal
//               window and five line buffers and emits full-pel, H half-pel,
//               V half-pel or H quarter-pel samples through a one-deep
//               output register.
// Revision    : 1.0 - initial release
// ============================================================================
module subpel_interp_stream #(
    parameter int PIX_W      = 8,
    parameter int LINE_LEN   = 8,
    parameter int FRAME_ROWS = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    subpel_interp_stream_if.slave   bus
);
    localparam int XW = (LINE_LEN   > 1) ? $clog2(LINE_LEN)   : 1;
    localparam int YW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
    localparam int SW = PIX_W + 7;

    localparam logic [XW-1:0]        c_x_last = XW'(LINE_LEN - 1);
    localparam logic [XW-1:0]        c_x_min  = XW'(5);
    localparam logic [YW-1:0]        c_y_last = YW'(FRAME_ROWS - 1);
    localparam logic [YW-1:0]        c_y_min  = YW'(5);
    localparam logic signed [SW-1:0] c_k5     = SW'(5);
    localparam logic signed [SW-1:0] c_k16    = SW'(16);
    localparam logic signed [SW-1:0] c_k20    = SW'(20);
    localparam logic signed [SW-1:0] c_zero   = '0;
    localparam logic signed [SW-1:0] c_max    = $signed({7'b0, {PIX_W{1'b1}}});

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [1:0]       r_mode;
    // Five most recent processed pixels, oldest at index 0; the incoming
    // pixel completes the six-tap window.
    logic [PIX_W-1:0] r_h  [0:4];
    logic [PIX_W-1:0] r_lb [0:4][0:LINE_LEN-1];
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_pix;
    logic             r_frame_done;
    logic             r_frame_err;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_sof;
    logic             w_proc;
    logic [XW-1:0]    w_cx;
    logic [YW-1:0]    w_cy;
    logic [1:0]       w_mode;
    logic [PIX_W-1:0] w_hhalf;
    logic [PIX_W-1:0] w_vhalf;
    logic [PIX_W:0]   w_qsum;
    logic [PIX_W-1:0] w_quarter;
    logic             w_emit;
    logic [PIX_W-1:0] w_sample;

    function automatic logic signed [SW-1:0] f_ext(input logic [PIX_W-1:0] v);
        return $signed({7'b0, v});
    endfunction

    // Taps ordered oldest to newest; rounded, shifted and clipped to pixel range.
    function automatic logic [PIX_W-1:0] f_tap6(
        input logic [PIX_W-1:0] t0, t1, t2, t3, t4, t5
    );
        logic signed [SW-1:0] s;
        s = f_ext(t0) - c_k5 * f_ext(t1) + c_k20 * f_ext(t2)
          + c_k20 * f_ext(t3) - c_k5 * f_ext(t4) + f_ext(t5);
        s = (s + c_k16) >>> 5;
        if (s < c_zero)
            f_tap6 = '0;
        else if (s > c_max)
            f_tap6 = '1;
        else
            f_tap6 = s[PIX_W-1:0];
    endfunction

    assign w_in_ready     = !r_out_valid || bus.out_ready;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_pix    = r_out_pix;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;

    // Accept qualification, effective coordinates/mode and sample selection.
    always_comb begin
        w_accept  = bus.in_valid && w_in_ready;
        w_sof     = w_accept && bus.in_sof;
        w_proc    = w_sof || (w_accept && (r_state == S_RUN));
        w_cx      = w_sof ? '0 : r_x;
        w_cy      = w_sof ? '0 : r_y;
        w_mode    = w_sof ? bus.mode : r_mode;
        w_hhalf   = f_tap6(r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], bus.in_pix);
        w_vhalf   = f_tap6(r_lb[4][w_cx], r_lb[3][w_cx], r_lb[2][w_cx],
                           r_lb[1][w_cx], r_lb[0][w_cx], bus.in_pix);
        // r_h[2] is the full-pel sample just left of the half-pel position.
        w_qsum    = {1'b0, r_h[2]} + {1'b0, w_hhalf} + (PIX_W+1)'(1);
        w_quarter = PIX_W'(w_qsum >> 1);
        w_emit    = 1'b0;
        w_sample  = bus.in_pix;
        case (w_mode)
            2'd0: begin
                w_emit   = 1'b1;
                w_sample = bus.in_pix;
            end
            2'd1: begin
                w_emit   = (w_cx >= c_x_min);
                w_sample = w_hhalf;
            end
            2'd2: begin
                w_emit   = (w_cy >= c_y_min);
                w_sample = w_vhalf;
            end
            default: begin
                w_emit   = (w_cx >= c_x_min);
                w_sample = w_quarter;
            end
        endcase
    end

    // Frame FSM, raster counters, H window and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_mode       <= '0;
            for (int i = 0; i < 5; i++)
                r_h[i] <= '0;
            r_out_valid  <= 1'b0;
            r_out_pix    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_sof && (r_state == S_RUN))
                r_frame_err <= 1'b1;
            if (w_proc) begin
                for (int i = 0; i < 4; i++)
                    r_h[i] <= r_h[i+1];
                r_h[4] <= bus.in_pix;
                r_mode <= w_mode;
                if (w_cx == c_x_last) begin
                    r_x <= '0;
                    if (w_cy == c_y_last) begin
                        r_y          <= '0;
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_y     <= w_cy + 1'b1;
                        r_state <= S_RUN;
                    end
                end else begin
                    r_x     <= w_cx + 1'b1;
                    r_y     <= w_cy;
                    r_state <= S_RUN;
                end
            end
            if (w_proc && w_emit) begin
                r_out_valid <= 1'b1;
                r_out_pix   <= w_sample;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Column-wise line-buffer shift; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_proc) begin
            for (int k = 4; k > 0; k--)
                r_lb[k][w_cx] <= r_lb[k-1][w_cx];
            r_lb[0][w_cx] <= bus.in_pix;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_subpel_interp_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_subpel_interp_stream
// Description : Self-checking bench for subpel_interp_stream: frame-level
//               image model, sample queue scoreboard, randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subpel_interp_stream;
    localparam int PIX_W      = 8;
    localparam int LINE_LEN   = 8;
    localparam int FRAME_ROWS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    subpel_interp_stream_if #(.PIX_W(PIX_W)) bus();

    subpel_interp_stream #(
        .PIX_W(PIX_W), .LINE_LEN(LINE_LEN), .FRAME_ROWS(FRAME_ROWS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int exp_q[$];
    int got_q[$];
    int sent_q[$];
    bit exp_done = 1'b0;
    bit exp_err  = 1'b0;
    int done_cnt = 0;

    bit running = 1'b0;
    int mx, my, mmode;
    int img [FRAME_ROWS][LINE_LEN];

    int ordy_pct = 100;
    int gap_pct  = 0;
    int hold_low = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int filt(input int a, b, c, d, e, f);
        int s;
        s = a - 5*b + 20*c + 20*d - 5*e + f;
        s = (s + 16) >>> 5;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Image-level model: store the pixel at its raster position and derive
    // the required sample directly from the frame contents.
    task automatic model_accept(input int p, input bit s, input int m);
        int half;
        if (s) begin
            if (running) exp_err = 1'b1;
            mx = 0; my = 0; mmode = m; running = 1'b1;
        end else if (!running) begin
            return;
        end
        img[my][mx] = p;
        case (mmode)
            0: exp_q.push_back(p);
            1: if (mx >= 5)
                   exp_q.push_back(filt(img[my][mx-5], img[my][mx-4], img[my][mx-3],
                                        img[my][mx-2], img[my][mx-1], img[my][mx]));
            2: if (my >= 5)
                   exp_q.push_back(filt(img[my-5][mx], img[my-4][mx], img[my-3][mx],
                                        img[my-2][mx], img[my-1][mx], img[my][mx]));
            default: if (mx >= 5) begin
                half = filt(img[my][mx-5], img[my][mx-4], img[my][mx-3],
                            img[my][mx-2], img[my][mx-1], img[my][mx]);
                exp_q.push_back((img[my][mx-3] + half + 1) / 2);
            end
        endcase
        if (mx == LINE_LEN-1) begin
            mx = 0;
            if (my == FRAME_ROWS-1) begin
                my = 0; running = 1'b0; exp_done = 1'b1;
            end else begin
                my++;
            end
        end else begin
            mx++;
        end
    endtask

    // Output checker: runs every cycle, just after the falling edge.
    initial begin
        bit hold;
        int hold_pix;
        hold = 1'b0;
        hold_pix = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold = 1'b0;
            end else begin
                chk("frame_done", int'(bus.frame_done), int'(exp_done));
                if (bus.frame_done) done_cnt++;
                exp_done = 1'b0;
                chk("frame_err", int'(bus.frame_err), int'(exp_err));
                if (hold) begin
                    chk("hold_valid", int'(bus.out_valid), 1);
                    chk("hold_pix", int'(bus.out_pix), hold_pix);
                end
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL out_unexpected: got sample %0d, none required (t=%0t)",
                                     bus.out_pix, $time);
                        end else begin
                            chk("out_pix", int'(bus.out_pix), exp_q.pop_front());
                        end
                        got_q.push_back(int'(bus.out_pix));
                    end
                    hold     = !bus.out_ready;
                    hold_pix = int'(bus.out_pix);
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    task automatic step(input bit v, input int p, input bit s, input int m, output bit acc);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_pix   = PIX_W'(p);
        bus.in_sof   = s;
        bus.mode     = 2'(m);
        if (hold_low > 0) begin
            bus.out_ready = 1'b0;
            hold_low--;
        end else begin
            bus.out_ready = ($urandom_range(0, 99) < ordy_pct);
        end
        #2;
        chk("in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
        acc = v && bus.in_ready;
        if (acc) model_accept(p, s, m);
    endtask

    task automatic send(input int p, input bit s, input int m);
        bit acc;
        int tries;
        while ($urandom_range(0, 99) < gap_pct)
            step(1'b0, int'($urandom_range(0, 255)), 1'b0, m, acc);
        tries = 0;
        acc   = 1'b0;
        while (!acc) begin
            step(1'b1, p, s, m, acc);
            tries++;
            if (!acc && tries > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: pixel %0d not accepted in %0d cycles", p, tries);
                return;
            end
        end
        sent_q.push_back(p);
    endtask

    function automatic int pix_of(input int kind, input int x, input int y);
        case (kind)
            0: return 10;
            1: if (y == 0) return (x == 2 || x == 3) ? 255 : 0;
               else if (y == 1) return (x < 2 || x == 4 || x == 5) ? 255 : 0;
               else return int'($urandom_range(0, 255));
            2: return x * 16;
            3: return (y == 2 || y == 3) ? 255 : 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_frame(input int kind, input int m);
        for (int y = 0; y < FRAME_ROWS; y++)
            for (int x = 0; x < LINE_LEN; x++)
                send(pix_of(kind, x, y), (x == 0 && y == 0), m);
    endtask

    task automatic drain();
        bit acc;
        int n;
        int save;
        save = ordy_pct;
        ordy_pct = 100;
        n = 0;
        do begin
            step(1'b0, 0, 1'b0, 0, acc);
            n++;
        end while ((exp_q.size() != 0 || bus.out_valid) && n < 100);
        step(1'b0, 0, 1'b0, 0, acc);
        step(1'b0, 0, 1'b0, 0, acc);
        chk("drain_queue_empty", exp_q.size(), 0);
        ordy_pct = save;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        exp_q.delete();
        running  = 1'b0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int d0;
        bus.in_valid  = 1'b0;
        bus.in_pix    = '0;
        bus.in_sof    = 1'b0;
        bus.mode      = 2'd0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_out_pix", int'(bus.out_pix), 0);
        chk("reset_frame_done", int'(bus.frame_done), 0);
        chk("reset_frame_err", int'(bus.frame_err), 0);
        chk("reset_in_ready", int'(bus.in_ready), 1);

        chk("model_saturate", filt(0, 0, 255, 255, 0, 0), 255);
        chk("model_clip_low", filt(255, 255, 0, 0, 255, 255), 0);
        chk("model_ramp_half", filt(0, 16, 32, 48, 64, 80), 40);

        // Flat frame, H half-pel
        got_q.delete(); d0 = done_cnt;
        send_frame(0, 1);
        drain();
        chk("flat_count", got_q.size(), 24);
        foreach (got_q[i]) chk("flat_value", got_q[i], 10);
        chk("flat_done_pulses", done_cnt - d0, 1);
        chk("flat_err", int'(bus.frame_err), 0);

        // Saturating / clipping edges, H half-pel
        got_q.delete();
        send_frame(1, 1);
        drain();
        chk("edge_count", got_q.size(), 24);
        if (got_q.size() >= 4) begin
            chk("edge_saturate", got_q[0], 255);
            chk("edge_clip_low", got_q[3], 0);
        end

        // Ramp, H quarter-pel
        got_q.delete();
        send_frame(2, 3);
        drain();
        chk("ramp_count", got_q.size(), 24);
        if (got_q.size() >= 3) begin
            chk("ramp_q_x5", got_q[0], 36);
            chk("ramp_q_x6", got_q[1], 52);
            chk("ramp_q_x7", got_q[2], 68);
        end

        // Vertical half-pel
        got_q.delete(); d0 = done_cnt;
        send_frame(3, 2);
        drain();
        chk("vert_count", got_q.size(), 24);
        if (got_q.size() >= 1) chk("vert_first", got_q[0], 255);
        chk("vert_done_pulses", done_cnt - d0, 1);

        // Full-pel with a 3-cycle downstream stall mid-stream
        got_q.delete(); sent_q.delete();
        for (int i = 0; i < LINE_LEN*FRAME_ROWS; i++) begin
            if (i == 20) hold_low = 3;
            send(pix_of(4, 0, 0), (i == 0), 0);
        end
        drain();
        chk("stall_count", got_q.size(), LINE_LEN*FRAME_ROWS);
        if (got_q.size() == sent_q.size())
            foreach (got_q[i]) chk("stall_order", got_q[i], sent_q[i]);

        // Randomized frames, modes, gaps and backpressure
        ordy_pct = 70; gap_pct = 20;
        for (int f = 0; f < 6; f++)
            send_frame(4, int'($urandom_range(0, 3)));
        drain();
        ordy_pct = 100; gap_pct = 0;

        // sof reissued at (3,2)
        got_q.delete(); d0 = done_cnt;
        for (int i = 0; i < 2*LINE_LEN + 3; i++)
            send(pix_of(4, 0, 0), (i == 0), 0);
        send_frame(4, 0);
        drain();
        chk("resof_err", int'(bus.frame_err), 1);
        chk("resof_done_pulses", done_cnt - d0, 1);
        chk("resof_count", got_q.size(), 2*LINE_LEN + 3 + LINE_LEN*FRAME_ROWS);

        // Reset mid-frame with a sample stuck in the output register
        ordy_pct = 0;
        send(77, 1'b1, 0);
        step(1'b0, 0, 1'b0, 0, acc);
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        reset_mid();
        ordy_pct = 100;
        got_q.delete(); d0 = done_cnt;
        for (int i = 0; i < 10; i++) send(pix_of(4, 0, 0), 1'b0, 0);
        repeat (4) step(1'b0, 0, 1'b0, 0, acc);
        chk("dropped_no_output", got_q.size(), 0);
        send_frame(4, 2);
        drain();
        chk("post_rst_count", got_q.size(), 24);
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_err", int'(bus.frame_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
